// File: rtl/rf_pkg.sv
// Shared register-file constants for the write-back path and its clients.
package rf_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from last_grant+1 (mod NUM_SRC) and grants
// the first active request.
module rr_arbiter #(
  parameter int NUM_SRC = 3,
  localparam int IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_SRC-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  int cand_s;

  // Priority search in rotated order; first hit wins.
  always_comb begin
    grant       = {NUM_SRC{1'b0}};
    grant_idx   = {IDX_W{1'b0}};
    grant_valid = 1'b0;
    cand_s      = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand_s = (int'(last_grant) + k) % NUM_SRC;
      if (!grant_valid && req[cand_s]) begin
        grant[cand_s] = 1'b1;
        grant_idx     = IDX_W'(cand_s);
        grant_valid   = 1'b1;
      end else begin
        grant_valid = grant_valid;
      end
    end
  end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Write-back scheduler: arbitrates requesters onto the single register-file
// write port and tracks outstanding writes in a per-register scoreboard.
module rf_wb_scheduler #(
  parameter int NUM_SRC = 3,
  parameter int ADDR_W  = rf_pkg::ADDR_W,
  parameter int DATA_W  = rf_pkg::DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic                      rsv_valid,
  input  logic [ADDR_W-1:0]         rsv_addr,
  output logic                      rsv_ready,
  input  logic [ADDR_W-1:0]         chk_addr_a,
  input  logic [ADDR_W-1:0]         chk_addr_b,
  output logic                      busy_a,
  output logic                      busy_b,
  output logic                      wt_en,
  output logic [ADDR_W-1:0]         wt_addr,
  output logic [DATA_W-1:0]         wt_data,
  output logic [31:0]               pending
);

  import rf_pkg::NUM_REGS;

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(NUM_SRC - 1);
  localparam logic [ADDR_W-1:0] ZERO_A   = {ADDR_W{1'b0}};

  logic [IDX_W-1:0]    last_grant_r;
  logic [NUM_SRC-1:0]  grant_s;
  logic [IDX_W-1:0]    grant_idx_s;
  logic                grant_valid_s;
  logic                accept_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_data_s;
  logic                wt_en_r;
  logic [ADDR_W-1:0]   wt_addr_r;
  logic [DATA_W-1:0]   wt_data_r;
  logic [NUM_REGS-1:0] pending_r;
  logic [NUM_REGS-1:0] pending_nxt_s;
  logic                rsv_ready_s;
  logic                rsv_set_s;

  rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
    .req         (src_valid),
    .last_grant  (last_grant_r),
    .grant       (grant_s),
    .grant_idx   (grant_idx_s),
    .grant_valid (grant_valid_s)
  );

  // Ready is suppressed while reset is held so nothing is consumed and lost.
  always_comb begin
    if (rst) begin
      src_ready = {NUM_SRC{1'b0}};
      accept_s  = 1'b0;
    end else begin
      src_ready = grant_s;
      accept_s  = grant_valid_s;
    end
  end

  // Mux the granted requester's destination and data.
  always_comb begin
    sel_addr_s = src_addr[grant_idx_s*ADDR_W +: ADDR_W];
    sel_data_s = src_data[grant_idx_s*DATA_W +: DATA_W];
  end

  // A pending register may be re-reserved in the cycle its write commits.
  always_comb begin
    if (rsv_addr == ZERO_A) begin
      rsv_ready_s = 1'b1;
    end else if (!pending_r[rsv_addr]) begin
      rsv_ready_s = 1'b1;
    end else if (wt_en_r && (wt_addr_r == rsv_addr)) begin
      rsv_ready_s = 1'b1;
    end else begin
      rsv_ready_s = 1'b0;
    end
    rsv_set_s = rsv_valid && rsv_ready_s && (rsv_addr != ZERO_A);
  end

  // Clear on commit first, then apply reservation so a same-edge set wins.
  always_comb begin
    pending_nxt_s = pending_r;
    if (wt_en_r) begin
      pending_nxt_s[wt_addr_r] = 1'b0;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
    if (rsv_set_s) begin
      pending_nxt_s[rsv_addr] = 1'b1;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
    pending_nxt_s[0] = 1'b0;
  end

  // Busy lookups; R0 is never busy.
  always_comb begin
    busy_a = (chk_addr_a != ZERO_A) && pending_r[chk_addr_a];
    busy_b = (chk_addr_b != ZERO_A) && pending_r[chk_addr_b];
  end

  // Output register stage, scoreboard state and arbitration pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_r <= LAST_RST;
      wt_en_r      <= 1'b0;
      wt_addr_r    <= {ADDR_W{1'b0}};
      wt_data_r    <= {DATA_W{1'b0}};
      pending_r    <= {NUM_REGS{1'b0}};
    end else begin
      pending_r <= pending_nxt_s;
      if (accept_s) begin
        last_grant_r <= grant_idx_s;
        if (sel_addr_s != ZERO_A) begin
          wt_en_r   <= 1'b1;
          wt_addr_r <= sel_addr_s;
          wt_data_r <= sel_data_s;
        end else begin
          wt_en_r <= 1'b0;
        end
      end else begin
        wt_en_r <= 1'b0;
      end
    end
  end

  assign rsv_ready = rsv_ready_s;
  assign wt_en     = wt_en_r;
  assign wt_addr   = wt_addr_r;
  assign wt_data   = wt_data_r;
  assign pending   = pending_r;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Randomised and directed bench for rf_wb_scheduler against a behavioural
// model of arbitration, write-back latency and the pending scoreboard.
module tb_rf_wb_scheduler;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    src_valid;
  logic [N-1:0]    src_ready;
  logic [N*AW-1:0] src_addr;
  logic [N*DW-1:0] src_data;
  logic            rsv_valid;
  logic [AW-1:0]   rsv_addr;
  logic            rsv_ready;
  logic [AW-1:0]   chk_addr_a;
  logic [AW-1:0]   chk_addr_b;
  logic            busy_a;
  logic            busy_b;
  logic            wt_en;
  logic [AW-1:0]   wt_addr;
  logic [DW-1:0]   wt_data;
  logic [31:0]     pending;

  rf_wb_scheduler #(.NUM_SRC(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_addr(src_addr), .src_data(src_data),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
    .chk_addr_a(chk_addr_a), .chk_addr_b(chk_addr_b),
    .busy_a(busy_a), .busy_b(busy_b),
    .wt_en(wt_en), .wt_addr(wt_addr), .wt_data(wt_data),
    .pending(pending)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: what the register-file port and scoreboard should show.
  logic [31:0]   m_pend;
  int            m_last;
  logic          m_wt_en;
  logic [AW-1:0] m_wt_addr;
  logic [DW-1:0] m_wt_data;

  // Requester holding registers (held until accepted).
  logic          r_valid [N];
  logic [AW-1:0] r_addr  [N];
  logic [DW-1:0] r_data  [N];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      src_valid[i]          = r_valid[i];
      src_addr[i*AW +: AW]  = r_addr[i];
      src_data[i*DW +: DW]  = r_data[i];
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    r_valid[i] = 1'b1;
    r_addr[i]  = a;
    r_data[i]  = d;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) r_valid[i] = 1'b0;
  endtask

  // One clock cycle: check combinational outputs, clock, update model, check registers.
  task automatic step();
    int          gidx;
    logic [N-1:0] exp_rdy;
    logic        exp_rr;
    logic [31:0] nxt_pend;
    drive();
    #1;
    gidx    = -1;
    exp_rdy = '0;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_last + k) % N;
      if (gidx < 0 && r_valid[c]) gidx = c;
    end
    if (gidx >= 0) exp_rdy[gidx] = 1'b1;
    exp_rr = (rsv_addr == 5'd0) || !m_pend[rsv_addr] || (m_wt_en && m_wt_addr == rsv_addr);
    check_val("src_ready", 64'(src_ready), 64'(exp_rdy));
    check_val("rsv_ready", 64'(rsv_ready), 64'(exp_rr));
    check_val("busy_a", 64'(busy_a), 64'((chk_addr_a != 5'd0) && m_pend[chk_addr_a]));
    check_val("busy_b", 64'(busy_b), 64'((chk_addr_b != 5'd0) && m_pend[chk_addr_b]));
    nxt_pend = m_pend;
    if (m_wt_en) nxt_pend[m_wt_addr] = 1'b0;
    if (rsv_valid && exp_rr && rsv_addr != 5'd0) nxt_pend[rsv_addr] = 1'b1;
    @(posedge clk);
    #1;
    m_pend = nxt_pend;
    if (gidx >= 0) begin
      m_last  = gidx;
      m_wt_en = (r_addr[gidx] != 5'd0);
      if (m_wt_en) begin
        m_wt_addr = r_addr[gidx];
        m_wt_data = r_data[gidx];
      end
      r_valid[gidx] = 1'b0;
    end else begin
      m_wt_en = 1'b0;
    end
    check_val("wt_en", 64'(wt_en), 64'(m_wt_en));
    check_val("wt_addr", 64'(wt_addr), 64'(m_wt_addr));
    check_val("wt_data", 64'(wt_data), 64'(m_wt_data));
    check_val("pending", 64'(pending), 64'(m_pend));
  endtask

  task automatic do_reset();
    drive();
    rst = 1'b1;
    #1;
    m_pend    = 32'd0;
    m_last    = N - 1;
    m_wt_en   = 1'b0;
    m_wt_addr = 5'd0;
    m_wt_data = 32'd0;
    check_val("rst_src_ready", 64'(src_ready), 64'd0);
    check_val("rst_wt_en", 64'(wt_en), 64'd0);
    check_val("rst_pending", 64'(pending), 64'd0);
    check_val("rst_wt_addr", 64'(wt_addr), 64'd0);
    check_val("rst_wt_data", 64'(wt_data), 64'd0);
    @(posedge clk);
    #1;
    check_val("rst_hold_ready", 64'(src_ready), 64'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    rsv_valid  = 1'b0;
    rsv_addr   = 5'd0;
    chk_addr_a = 5'd0;
    chk_addr_b = 5'd0;
    src_valid  = '0;
    src_addr   = '0;
    src_data   = '0;
    for (int i = 0; i < N; i++) set_req(i, 5'(i + 1), 32'h100 + 32'(i));
    @(negedge clk);
    do_reset();

    // All sources continuously valid: rotating grants, wt_en every cycle.
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < N; i++) set_req(i, 5'(i + 1), 32'h200 + 32'(c * 4 + i));
      step();
    end
    clear_reqs();
    step();

    // Single write latency.
    set_req(1, 5'd7, 32'hDEADBEEF);
    step();
    step();

    // Scoreboard lifecycle on R5.
    chk_addr_a = 5'd5;
    rsv_valid = 1'b1; rsv_addr = 5'd5;
    step();
    rsv_valid = 1'b0;
    step();
    rsv_valid = 1'b1;
    step();
    rsv_valid = 1'b0;
    set_req(0, 5'd5, 32'h5555_0005);
    step();
    step();
    step();

    // Reserve R9 in the cycle its write commits.
    chk_addr_b = 5'd9;
    rsv_valid = 1'b1; rsv_addr = 5'd9;
    step();
    rsv_valid = 1'b0;
    set_req(2, 5'd9, 32'h9999_0009);
    step();
    rsv_valid = 1'b1;
    step();
    rsv_valid = 1'b0;
    step();
    check_val("r9_still_pending", 64'(pending[9]), 64'd1);
    set_req(1, 5'd9, 32'h9999_1009);
    step();
    step();

    // Zero register: write, reserve and busy lookups.
    chk_addr_a = 5'd0;
    set_req(0, 5'd0, 32'hFFFF_FFFF);
    rsv_valid = 1'b1; rsv_addr = 5'd0;
    step();
    rsv_valid = 1'b0;
    step();

    // Reset during a wt_en cycle with R3/R4 pending.
    rsv_valid = 1'b1; rsv_addr = 5'd3;
    step();
    rsv_addr = 5'd4;
    step();
    rsv_valid = 1'b0;
    set_req(1, 5'd3, 32'h3333_0003);
    step();
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 5'(i + 10), 32'h400 + 32'(i));
    step();
    clear_reqs();

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!r_valid[i] && $urandom_range(0, 1) == 1)
          set_req(i, 5'($urandom_range(0, 7)), $urandom);
      end
      rsv_valid  = 1'($urandom_range(0, 1));
      rsv_addr   = 5'($urandom_range(0, 7));
      chk_addr_a = 5'($urandom_range(0, 7));
      chk_addr_b = 5'($urandom_range(0, 7));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
